// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: sweep sequencer and round-robin query arbiter for a
// 5-input combinational function block (fn_code -> fn_f).
// Optional build macro: KMAP_SWEEP_CACHE_EN answers queries from the last
// captured truth table instead of driving the function block.
module kmap_sweep_ctrl #(
    parameter int NREQ   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [31:0]          truth_mask,
    output logic [5:0]           ones_count,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_code,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_f,
    output logic [4:0]           fn_code,
    input  logic                 fn_f
);

    localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2,
        QUERY = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [4:0]      idx, idx_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   win, win_nxt;
    logic [4:0]      qcode, qcode_nxt;

    logic [31:0]     mask_nxt;
    logic [5:0]      ones_nxt;
    logic [4:0]      fn_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            rsp_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    logic            found;
    logic [PW-1:0]   pick;
    logic [4:0]      pick_code;

`ifdef KMAP_SWEEP_CACHE_EN
    logic            cache_valid, cache_nxt;
`endif

    // Round-robin pick: first asserted request at or above the pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (!found && req[(32'(ptr) + j) % NR]) begin
                found = 1'b1;
                pick  = PW'((32'(ptr) + j) % NR);
            end
        end
        pick_code = req_code[32'(pick)*5 +: 5];
    end

    // Next-state and next-output logic; every output is registered from these
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        win_nxt   = win;
        qcode_nxt = qcode;
        mask_nxt  = truth_mask;
        ones_nxt  = ones_count;
        fn_nxt    = fn_code;
        gnt_nxt   = '0;
        rsp_nxt   = rsp_f;
        done_nxt  = 1'b0;
`ifdef KMAP_SWEEP_CACHE_EN
        cache_nxt = cache_valid;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt  = '0;
                    ones_nxt  = '0;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    fn_nxt    = '0;
                    state_nxt = SWEEP;
`ifdef KMAP_SWEEP_CACHE_EN
                    cache_nxt = 1'b0;
`endif
                end else if (found) begin
                    win_nxt   = pick;
                    qcode_nxt = pick_code;
                    cnt_nxt   = '0;
                    state_nxt = QUERY;
`ifdef KMAP_SWEEP_CACHE_EN
                    if (!cache_valid) fn_nxt = pick_code;
`else
                    fn_nxt = pick_code;
`endif
                end
            end

            SWEEP: begin
                if (cnt == 3'(SETTLE - 1)) begin
                    cnt_nxt       = '0;
                    mask_nxt[idx] = fn_f;
                    ones_nxt      = ones_count + {5'd0, fn_f};
                    if (idx == 5'd31) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 5'd1;
                        fn_nxt  = idx + 5'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end

            // DONE spans two cycles: the registered sweep_done marks the second
            DONE: begin
                if (!sweep_done) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
`ifdef KMAP_SWEEP_CACHE_EN
                    cache_nxt = 1'b1;
`endif
                end
            end

            QUERY: begin
`ifdef KMAP_SWEEP_CACHE_EN
                if (cache_valid) begin
                    gnt_nxt[win] = 1'b1;
                    rsp_nxt      = truth_mask[qcode];
                    ptr_nxt      = (32'(win) + 1 == NR) ? '0 : win + 1'b1;
                    state_nxt    = IDLE;
                end else
`endif
                if (cnt == 3'(SETTLE)) begin
                    gnt_nxt[win] = 1'b1;
                    rsp_nxt      = fn_f;
                    ptr_nxt      = (32'(win) + 1 == NR) ? '0 : win + 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end

            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == SWEEP) || (state_nxt == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            ptr        <= '0;
            win        <= '0;
            qcode      <= '0;
            truth_mask <= '0;
            ones_count <= '0;
            fn_code    <= '0;
            gnt        <= '0;
            rsp_f      <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            ptr        <= ptr_nxt;
            win        <= win_nxt;
            qcode      <= qcode_nxt;
            truth_mask <= mask_nxt;
            ones_count <= ones_nxt;
            fn_code    <= fn_nxt;
            gnt        <= gnt_nxt;
            rsp_f      <= rsp_nxt;
            sweep_busy <= busy_nxt;
            sweep_done <= done_nxt;
        end
    end

`ifdef KMAP_SWEEP_CACHE_EN
    // Cached truth table validity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cache_valid <= 1'b0;
        else        cache_valid <= cache_nxt;
    end
`endif

endmodule
